instr_feeder: RTL and testbench
===============================

Name: instr_feeder

Overview:
- Upstream instruction source for the 9-bit bus processor.
- Holds a small writable program memory and presents each instruction word on the processor's DIN with a one-cycle Run pulse.
- Supplies the immediate word for mvi on the following cycle, then waits for the processor's Done before advancing PC.
- Stops on a HALT opcode.

Parameters:
- ADDR_W, 5, program address width; DEPTH = 2**ADDR_W words.
- DATA_W, 9, instruction/data word width; must match the processor bus.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clock  in  1  clock, rising edge.
- Resetn  in  1  reset; asynchronous, active-low.
- Start  in  1  begin execution at address 0; honoured in IDLE or HALT only.
- LoadEn  in  1  program-memory write strobe; honoured in IDLE or HALT only.
- LoadAddr  in  ADDR_W  write address.
- LoadData  in  DATA_W  write data.
- Done  in  1  processor instruction-complete flag.
- DIN  out  DATA_W  word presented to the processor.
- Run  out  1  one-cycle instruction-issue pulse.
- PC  out  ADDR_W  address of the current instruction.
- Busy  out  1  high in ISSUE, EXEC and (with the option) PAUSE.
- Halted  out  1  high in HALT.
- Count  out  CNT_W  instructions retired since Start; saturates at all-ones.

Behaviour:
- Encoding: word[8:6]=opcode, [5:3]=X, [2:0]=Y.
  - Opcodes: mv=000, mvi=001, add=010, sub=011, HALT=111.
  - 100/101/110 are treated as 1-word instructions and issued normally.
- Memory: DEPTH x DATA_W register array.
  - Synchronous write; asynchronous read.
  - Not reset. Writes in any other state are dropped.
- State machine (registered): IDLE, ISSUE, EXEC, HALT, plus PAUSE with the option.
- Reset values: state=IDLE, PC=0, Count=0, Run=0, Busy=0, Halted=0, DIN=0.
  - Reset mid-execution aborts immediately; memory contents are kept.
- IDLE:
  - DIN=0.
  - Start=1 -> ISSUE with PC=0 and Count=0.
- ISSUE:
  - If mem[PC] opcode = HALT -> HALT; Run stays 0.
  - Otherwise Run=1 and DIN=mem[PC] for exactly this cycle -> EXEC.
- EXEC:
  - Run=0.
  - DIN = mem[PC+1] (mod DEPTH) if opcode is mvi, else mem[PC].
  - DIN is held until Done is sampled.
  - On Done=1 at a rising edge: PC += 2 for mvi, else PC += 1 (both wrap mod DEPTH); Count += 1 (saturating); -> ISSUE.
- Done is ignored outside EXEC.
- Timing against the processor:
  - ISSUE = processor T0.
  - The first EXEC cycle = T1, where mvi reads DIN and mv/mvi raise Done.
  - Throughput: mv/mvi 2 cycles; add/sub 4 cycles.
- HALT:
  - Halted=1, DIN=0, PC holds the address of the HALT word.
  - Start restarts from address 0.
  - LoadEn is allowed.
- Start while Busy is ignored. Start and LoadEn in the same cycle: the write occurs and execution starts; the first fetch sees the new data.
- Wrap cases:
  - PC at DEPTH-1 advancing by 1 -> 0.
  - mvi at DEPTH-1 takes its immediate from address 0 and the next PC is 1.
- All outputs decode from registered state/PC/memory only; there is no combinational path from Done to any output.

Optional Feature:
- Macro FEEDER_STEP_EN.
- Defined:
  - Adds input port Step (1 bit) and state PAUSE.
  - Retirement in EXEC goes to PAUSE instead of ISSUE, with PC/Count already updated.
  - PAUSE -> ISSUE on Step=1; Busy=1 and Run=0 while in PAUSE.
- Undefined: no Step port, no PAUSE state, back-to-back issue as described above.

Test Plan:
- Program {0x040,0x005,0x048,0x003,0x081,0x1C0} (mvi R0,#5; mvi R1,#3; add R0,R1; HALT) with the processor attached, Start -> Run pulses at PC 0, 2, 4; DIN=0x005 in the cycle after the first Run; final R0=8; Halted=1 with PC=5; Count=3.
- Stub Done model delaying Done 3 cycles after Run for opcode 010 -> DIN held at 0x081, Run low, PC stable until Done; then PC increments by 1.
- mvi at address 31 (ADDR_W=5) with mem[0]=0x0AA, run from address 31 via a preceding mv chain -> DIN=0x0AA during EXEC; next PC=1.
- Assert Resetn low during the EXEC of add -> next cycle state IDLE, Run=0, PC=0, Count=0; memory readback is unchanged on the next run.
- LoadEn pulse while Busy (addr 0, data 0x1C0) -> ignored; after HALT and restart, the original mem[0] executes.
- FEEDER_STEP_EN defined, 3-instruction program -> after each Done the block sits in PAUSE with Run=0 until a Step pulse; exactly one Run per Step.

Source files
------------

// File: rtl/instr_feeder.sv
//============================================================================
// Module   : instr_feeder
// Purpose  : Instruction source for the 9-bit bus processor. Holds a small
//            writable program memory, issues each word on DIN with a
//            one-cycle Run pulse, and feeds the mvi immediate word on the
//            following cycle. It then waits for Done before advancing PC,
//            and stops on the HALT opcode.
// Options  : `define FEEDER_STEP_EN adds a Step input and a PAUSE state.
//            With it, each retired instruction parks the feeder until a
//            Step pulse arrives.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module instr_feeder #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    input  logic              Done,
`ifdef FEEDER_STEP_EN
    input  logic              Step,
`endif
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic [CNT_W-1:0]  Count
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    // Opcode field values that change the feeder's sequencing
    localparam logic [2:0] c_OP_MVI  = 3'b001;
    localparam logic [2:0] c_OP_HALT = 3'b111;

    // Controller states
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_EXEC  = 3'd2;
    localparam logic [2:0] c_ST_HALT  = 3'd3;
`ifdef FEEDER_STEP_EN
    localparam logic [2:0] c_ST_PAUSE = 3'd4;
`endif

    // Program storage: not reset, so a program survives a reset abort
    logic [DATA_W-1:0] mem_q [c_DEPTH];

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] w_pc_p1;
    logic [ADDR_W-1:0] w_pc_p2;
    logic [DATA_W-1:0] w_cur_word;
    logic [DATA_W-1:0] w_next_word;
    logic [2:0]        w_opcode;
    logic              w_is_mvi;
    logic              w_is_halt;
    logic              w_ctrl_idle;
    logic              w_load_we;
    logic              w_retire;
    logic              w_cnt_max;

    // Both increments wrap naturally at the top of the address space.
    // This lets an mvi at the last address take its immediate from word 0.
    assign w_pc_p1     = pc_q + ADDR_W'(1);
    assign w_pc_p2     = w_pc_p1 + ADDR_W'(1);

    // Asynchronous read of the current word and its successor
    assign w_cur_word  = mem_q[pc_q];
    assign w_next_word = mem_q[w_pc_p1];

    assign w_opcode    = w_cur_word[DATA_W-1 -: 3];
    assign w_is_mvi    = (w_opcode == c_OP_MVI);
    assign w_is_halt   = (w_opcode == c_OP_HALT);

    // Loading and starting are only honoured while nothing is executing
    assign w_ctrl_idle = (state_q == c_ST_IDLE) || (state_q == c_ST_HALT);
    assign w_load_we   = LoadEn && w_ctrl_idle;

    // An instruction retires on the edge where Done is seen during EXEC
    assign w_retire    = (state_q == c_ST_EXEC) && Done;
    assign w_cnt_max   = (cnt_q == {CNT_W{1'b1}});

    // Program memory write port; writes outside IDLE/HALT are discarded
    always_ff @(posedge Clock) begin
        if (w_load_we) begin
            mem_q[LoadAddr] <= LoadData;
        end
    end

    // Next-state, PC and retired-count logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_ST_IDLE, c_ST_HALT: begin
                if (Start) begin
                    state_d = c_ST_ISSUE;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            c_ST_ISSUE: begin
                // A HALT word is never issued; PC stays on it
                if (w_is_halt) begin
                    state_d = c_ST_HALT;
                end else begin
                    state_d = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                if (w_retire) begin
                    pc_d = w_is_mvi ? w_pc_p2 : w_pc_p1;
                    if (!w_cnt_max) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`ifdef FEEDER_STEP_EN
                    state_d = c_ST_PAUSE;
`else
                    state_d = c_ST_ISSUE;
`endif
                end
            end
`ifdef FEEDER_STEP_EN
            c_ST_PAUSE: begin
                if (Step) begin
                    state_d = c_ST_ISSUE;
                end
            end
`endif
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset aborts any execution immediately
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= c_ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode from registered state, PC and memory only (no Done path)
    always_comb begin
        DIN    = '0;
        Run    = 1'b0;
        Busy   = 1'b0;
        Halted = 1'b0;
        case (state_q)
            c_ST_ISSUE: begin
                Busy = 1'b1;
                if (!w_is_halt) begin
                    Run = 1'b1;
                    DIN = w_cur_word;
                end
            end
            c_ST_EXEC: begin
                // mvi needs its immediate on the bus from T1 onwards
                Busy = 1'b1;
                DIN  = w_is_mvi ? w_next_word : w_cur_word;
            end
            c_ST_HALT: begin
                Halted = 1'b1;
            end
`ifdef FEEDER_STEP_EN
            c_ST_PAUSE: begin
                Busy = 1'b1;
            end
`endif
            default: begin
                DIN = '0;
            end
        endcase
    end

    assign PC    = pc_q;
    assign Count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_feeder.sv
//============================================================================
// Module   : tb_instr_feeder
// Purpose  : Scoreboard bench for instr_feeder. Expected issues (PC, issued
//            word, word held during EXEC) are queued by the stimulus thread.
//            A monitor pops them on every Run pulse. A stub processor drives
//            Done and keeps a tiny register model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_instr_feeder;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Start = 1'b0;
    logic       LoadEn = 1'b0;
    logic [4:0] LoadAddr = '0;
    logic [8:0] LoadData = '0;
    logic       Done;
    logic [8:0] DIN;
    logic       Run;
    logic [4:0] PC;
    logic       Busy;
    logic       Halted;
    logic [15:0] Count;

    logic       stub_done = 1'b0;
    logic       done_force = 1'b0;
    assign Done = stub_done | done_force;

`ifdef FEEDER_STEP_EN
    logic step_auto = 1'b1;
    logic step_man  = 1'b0;
    logic Step;
    assign Step = step_auto | step_man;
`endif

    instr_feeder #(.ADDR_W(5), .DATA_W(9), .CNT_W(16)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start),
        .LoadEn   (LoadEn),
        .LoadAddr (LoadAddr),
        .LoadData (LoadData),
        .Done     (Done),
`ifdef FEEDER_STEP_EN
        .Step     (Step),
`endif
        .DIN      (DIN),
        .Run      (Run),
        .PC       (PC),
        .Busy     (Busy),
        .Halted   (Halted),
        .Count    (Count)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [4:0] pc;
        logic [8:0] din;
        logic [8:0] hold;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         runs_seen = 0;
    logic [8:0] R [8];

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void push(logic [4:0] pc, logic [8:0] din, logic [8:0] hold);
        exp_t e;
        e.pc   = pc;
        e.din  = din;
        e.hold = hold;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [8:0] d);
        LoadEn = 1'b1; LoadAddr = a; LoadData = d;
        tick();
        LoadEn = 1'b0;
    endtask

    task automatic do_start();
        for (int i = 0; i < 8; i++) R[i] = '0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_halt(input int max);
        int n = 0;
        while (!Halted && n < max) begin
            tick();
            n++;
        end
        check("halt_reached", {31'd0, Halted}, 32'd1);
    endtask

    task automatic push_prog1();
        push(5'd0, 9'h040, 9'h005);
        push(5'd2, 9'h048, 9'h003);
        push(5'd4, 9'h081, 9'h081);
    endtask

    // Stub processor: Done in T1 for mv/mvi, in T3 for add/sub
    int stub_cnt = 0;
    always @(negedge Clock) begin
        if (!Resetn) begin
            stub_cnt  = 0;
            stub_done = 1'b0;
        end else if (Run) begin
            stub_cnt  = (DIN[8:7] == 2'b01) ? 3 : 1;
            stub_done = 1'b0;
        end else if (stub_cnt != 0) begin
            stub_cnt--;
            stub_done = (stub_cnt == 0);
        end else begin
            stub_done = 1'b0;
        end
    end

    // Monitor: pops an expectation per Run, checks the EXEC hold, models regs
    logic       in_exec = 1'b0;
    int         exec_cyc = 0;
    logic [2:0] cur_op = '0, cur_x = '0, cur_y = '0;
    logic [8:0] exp_hold = '0;
    logic [4:0] exp_pc = '0;
    always begin
        exp_t e;
        @(posedge Clock);
        #1;
        if (!Resetn) begin
            in_exec  = 1'b0;
            exec_cyc = 0;
        end else begin
            if (in_exec && Done) begin
                case (cur_op)
                    3'b000:  R[cur_x] = R[cur_y];
                    3'b010:  R[cur_x] = R[cur_x] + R[cur_y];
                    3'b011:  R[cur_x] = R[cur_x] - R[cur_y];
                    default: ;
                endcase
                in_exec = 1'b0;
            end
            if (Run) begin
                runs_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_run_pc", {27'd0, PC}, 32'hFFFF_FFFF);
                    exp_pc   = PC;
                    exp_hold = DIN;
                end else begin
                    e = exp_q.pop_front();
                    check("issue_pc", {27'd0, PC}, {27'd0, e.pc});
                    check("issue_din", {23'd0, DIN}, {23'd0, e.din});
                    exp_pc   = e.pc;
                    exp_hold = e.hold;
                end
                cur_op   = DIN[8:6];
                cur_x    = DIN[5:3];
                cur_y    = DIN[2:0];
                in_exec  = 1'b1;
                exec_cyc = 0;
            end else if (in_exec) begin
                check("exec_din_hold", {23'd0, DIN}, {23'd0, exp_hold});
                check("exec_pc_hold", {27'd0, PC}, {27'd0, exp_pc});
                if (exec_cyc == 0 && cur_op == 3'b001) R[cur_x] = DIN;
                exec_cyc++;
            end
        end
    end

    // Watchdog against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Reset values
        tick(); tick();
        check("rst_run", {31'd0, Run}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_halted", {31'd0, Halted}, 32'd0);
        check("rst_pc", {27'd0, PC}, 32'd0);
        check("rst_count", {16'd0, Count}, 32'd0);
        check("rst_din", {23'd0, DIN}, 32'd0);
        @(negedge Clock) Resetn = 1'b1;
        tick();

        // Program 1 with Start and LoadEn pulsed while busy (both ignored)
        load(5'd0, 9'h040); load(5'd1, 9'h005); load(5'd2, 9'h048);
        load(5'd3, 9'h003); load(5'd4, 9'h081); load(5'd5, 9'h1C0);
        push_prog1();
        do_start();
        tick();
        LoadEn = 1'b1; LoadAddr = 5'd0; LoadData = 9'h1C0; Start = 1'b1;
        tick();
        LoadEn = 1'b0; Start = 1'b0;
        wait_halt(100);
        check("p1_pc", {27'd0, PC}, 32'd5);
        check("p1_count", {16'd0, Count}, 32'd3);
        check("p1_din_halt", {23'd0, DIN}, 32'd0);
        check("p1_busy", {31'd0, Busy}, 32'd0);
        check("p1_r0", {23'd0, R[0]}, 32'd8);
        check("p1_queue", exp_q.size(), 32'd0);

        // Done outside EXEC has no effect
        done_force = 1'b1; tick(); done_force = 1'b0; tick();
        check("done_ign_count", {16'd0, Count}, 32'd3);
        check("done_ign_pc", {27'd0, PC}, 32'd5);

        // Restart (original mem[0] must run), then reset during add's EXEC
        push_prog1();
        do_start();
        n = 0;
        while (!(Run && DIN == 9'h081) && n < 50) begin tick(); n++; end
        check("add_issued", {31'd0, Run}, 32'd1);
        tick();
        @(negedge Clock) Resetn = 1'b0;
        tick();
        check("abort_run", {31'd0, Run}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_pc", {27'd0, PC}, 32'd0);
        check("abort_count", {16'd0, Count}, 32'd0);
        check("abort_queue", exp_q.size(), 32'd0);
        @(negedge Clock) Resetn = 1'b1;
        tick();

        // Rerun after abort: memory must be intact
        push_prog1();
        do_start();
        wait_halt(100);
        check("rerun_pc", {27'd0, PC}, 32'd5);
        check("rerun_count", {16'd0, Count}, 32'd3);
        check("rerun_r0", {23'd0, R[0]}, 32'd8);

        // Start and LoadEn together: first fetch sees the new HALT word
        LoadEn = 1'b1; LoadAddr = 5'd0; LoadData = 9'h1C0; Start = 1'b1;
        tick();
        LoadEn = 1'b0; Start = 1'b0;
        tick();
        check("ldst_halted", {31'd0, Halted}, 32'd1);
        check("ldst_pc", {27'd0, PC}, 32'd0);
        check("ldst_count", {16'd0, Count}, 32'd0);

        // Wrap: add at 0, mv chain 1..30, mvi at 31 takes mem[0], next PC=1
        load(5'd0, 9'h0AA);
        for (int a = 1; a < 31; a++) load(5'(a), 9'h000);
        load(5'd31, 9'h048);
        push(5'd0, 9'h0AA, 9'h0AA);
        for (int a = 1; a < 31; a++) push(5'(a), 9'h000, 9'h000);
        push(5'd31, 9'h048, 9'h0AA);
        push(5'd1, 9'h000, 9'h000);
        do_start();
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
        check("wrap_queue", exp_q.size(), 32'd0);
        check("wrap_count", {16'd0, Count}, 32'd32);
        @(negedge Clock) Resetn = 1'b0;
        tick();
        @(negedge Clock) Resetn = 1'b1;
        tick();
        exp_q.delete();

`ifdef FEEDER_STEP_EN
        // Single-step: one Run per Step, PAUSE holds Busy with Run low
        begin
            int base;
            step_auto = 1'b0;
            load(5'd0, 9'h040); load(5'd1, 9'h005); load(5'd2, 9'h008);
            load(5'd3, 9'h081); load(5'd4, 9'h1C0);
            push(5'd0, 9'h040, 9'h005);
            push(5'd2, 9'h008, 9'h008);
            push(5'd3, 9'h081, 9'h081);
            base = runs_seen;
            do_start();
            for (int k = 0; k < 3; k++) begin
                n = 0;
                while (Count != 16'(k + 1) && n < 50) begin tick(); n++; end
                check("step_retired", {16'd0, Count}, k + 1);
                tick();
                check("pause_run", {31'd0, Run}, 32'd0);
                check("pause_busy", {31'd0, Busy}, 32'd1);
                check("pause_runs", runs_seen - base, k + 1);
                step_man = 1'b1;
                tick();
                step_man = 1'b0;
            end
            wait_halt(20);
            check("step_pc", {27'd0, PC}, 32'd4);
            check("step_runs", runs_seen - base, 32'd3);
            check("step_r0", {23'd0, R[0]}, 32'd10);
            step_auto = 1'b1;
        end
`endif

        check("final_queue", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
